cone_miter_pipe: RTL and testbench
==================================

// Module: cone_miter_pipe
// PURPOSE
//  Streaming, pipelined evaluator/checker for parity-style logic cones (XOR/XNOR trees over selected inputs).
//  Each accepted input vector yields OUT_W cone outputs, compared against a supplied expected vector.
//  Mismatches are counted and the first mismatching vector index is latched.
//  Sits between the test-vector source and the result sink in the equivalence-check harness.
// PARAMETERS
//  IN_W    12  input vector width (primary inputs per vector)
//  OUT_W   4   number of cone outputs (channels)
//  STAGES  2   pipeline register stages, >=1; accept-to-output latency in cycles
//  CNT_W   16  width of vector index and mismatch counter
// PORTS
//  clk            in   1            single clock, rising edge
//  rst_n          in   1            asynchronous active-low reset
//  cfg_mask       in   OUT_W*IN_W   channel k uses in_vec bits set in cfg_mask[k*IN_W +: IN_W]
//  cfg_inv        in   OUT_W        1: channel k is XNOR-reduce, 0: XOR-reduce
//  clr            in   1            sync clear of counters and sticky capture
//  in_valid       in   1            input vector valid
//  in_ready       out  1            pipeline can accept
//  in_vec         in   IN_W         input vector
//  in_exp         in   OUT_W        expected cone outputs for in_vec
//  out_valid      out  1            result valid
//  out_ready      in   1            sink accepts result
//  out_val        out  OUT_W        computed cone outputs
//  out_mis        out  OUT_W        per-channel mismatch (out_val ^ expected)
//  out_idx        out  CNT_W        index of the vector that produced this result
//  mis_cnt        out  CNT_W        results with any mismatch, saturating
//  first_mis_vld  out  1            a mismatch has been captured since reset/clr
//  first_mis_idx  out  CNT_W        index of first mismatching result
//  busy           out  1            any stage holds valid data
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valids 0, out_valid=0, in_ready=1, out_val/out_mis/out_idx=0,
//    mis_cnt=0, first_mis_vld=0, first_mis_idx=0, vector index counter=0, busy=0. Mid-operation reset drops in-flight data.
//  - Cone: val[k] = ^(in_vec & mask_k) ^ cfg_inv[k]. Empty mask gives val[k]=cfg_inv[k].
//  - Transfer: in-side on in_valid&in_ready; out-side on out_valid&out_ready.
//  - Pipeline: STAGES valid/data slices; slice i loads when empty or slice i+1 loads (last: when out_ready).
//    Bubbles collapse; no combinational path out_ready->in_valid; in_ready is a function of slice state and out_ready only.
//  - Latency: exactly STAGES cycles from in transfer to out_valid with no stall; full throughput 1/cycle.
//  - Backpressure: with out_ready=0, pipeline holds STAGES vectors, then in_ready=0; no loss, no reorder, no duplication.
//  - out_valid/out_val/out_mis/out_idx stable while out_valid&!out_ready.
//  - Index: counter increments per in transfer, wraps at 2^CNT_W; value travels with the vector.
//  - cfg_mask/cfg_inv quasi-static: changed only while busy=0; results are undefined otherwise.
//  - Counting on out transfer with |out_mis: mis_cnt+1, saturating at 2^CNT_W-1;
//    if !first_mis_vld, latch out_idx and set first_mis_vld.
//  - clr=1: mis_cnt=0, first_mis_vld=0, first_mis_idx=0 next cycle. clr wins over a same-cycle mismatch,
//    which is not counted. clr does not touch pipeline contents or the index counter.
// STRUCTURE
//  - Package cone_miter_pkg: default widths, function xnor_reduce(vec, mask, inv), result struct {val, mis, idx}.
//  - Sub-module cone_pipe_slice: one valid/ready register slice, instantiated STAGES times via generate.
//  - Cone logic ahead of slice 0; retiming into later slices is allowed if latency is unchanged.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 2 in flight -> out_valid=0, mis_cnt=0, in_ready=1, busy=0 immediately.
//  2 Single vector: mask ch0=12'h003, inv0=1, in_vec=12'h001, exp=4'h0 -> out_val[0]=0, out_mis=0, out_valid at cycle +2.
//  3 Backpressure: 6 vectors, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted; all 6 delivered in order, idx 0..5.
//  4 Mismatch: 10 vectors, exp wrong on idx 3 and 7 -> mis_cnt=2, first_mis_idx=3, first_mis_vld=1.
//  5 clr coincident with mismatch transfer -> mis_cnt=0, first_mis_vld=0 next cycle; next mismatch idx is latched.
//  6 CNT_W=4: 20 mismatching vectors -> mis_cnt=15 (saturated), out_idx wraps 15->0, first_mis_idx=0.

Source files
------------

// File: rtl/cone_miter_pkg.sv
// rtl/cone_miter_pkg.sv - shared widths, result record and cone reduction helper
//
// Purpose: default parameter values for cone_miter_pipe, the per-vector result
// record layout, and the masked XOR/XNOR reduction used by every cone channel.
// Ports: none (package).

package cone_miter_pkg;

  localparam int IN_W_DEF   = 12;
  localparam int OUT_W_DEF  = 4;
  localparam int STAGES_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  // Widest input vector the reduction helper accepts; narrower vectors are
  // zero-extended by the caller, which leaves the parity unchanged.
  localparam int MAX_IN_W = 64;

  // Result record at default widths; the top declares the same layout sized
  // by its own parameters.
  typedef struct packed {
    logic [OUT_W_DEF-1:0] val;
    logic [OUT_W_DEF-1:0] mis;
    logic [CNT_W_DEF-1:0] idx;
  } cone_res_t;

  // Parity of the selected bits, optionally inverted (XNOR tree when inv=1).
  // An empty mask reduces to 0, so the result is simply inv.
  function automatic logic xnor_reduce(input logic [MAX_IN_W-1:0] vec,
                                       input logic [MAX_IN_W-1:0] mask,
                                       input logic                inv);
    return (^(vec & mask)) ^ inv;
  endfunction

endpackage

// File: rtl/cone_pipe_slice.sv
// rtl/cone_pipe_slice.sv - one valid/ready pipeline register slice
//
// Purpose: single-entry register slice; loads when empty or when its content
// is being taken downstream in the same cycle, so bubbles collapse and a full
// chain sustains one transfer per cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload

module cone_pipe_slice
  import cone_miter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Ready depends only on local state and downstream ready, never on in_valid.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cone_miter_pipe.sv
// rtl/cone_miter_pipe.sv - streaming parity-cone evaluator and miter checker
//
// Purpose: evaluates OUT_W masked XOR/XNOR cones per accepted input vector,
// compares them against the supplied expected vector, and carries the result
// with its vector index through STAGES register slices. Mismatching results
// are counted (saturating) and the index of the first one is captured.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_mask, cfg_inv           per-channel input selection and inversion
//   clr                         synchronous clear of mis_cnt / first-mismatch
//   in_valid/in_ready           input handshake; in_vec, in_exp payload
//   out_valid/out_ready         output handshake; out_val, out_mis, out_idx
//   mis_cnt                     mismatching results delivered, saturating
//   first_mis_vld/idx           first mismatching result since reset/clr
//   busy                        any slice holds valid data

module cone_miter_pipe
  import cone_miter_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OUT_W*IN_W-1:0] cfg_mask,
  input  logic [OUT_W-1:0]      cfg_inv,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_vec,
  input  logic [OUT_W-1:0]      in_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_val,
  output logic [OUT_W-1:0]      out_mis,
  output logic [CNT_W-1:0]      out_idx,
  output logic [CNT_W-1:0]      mis_cnt,
  output logic                  first_mis_vld,
  output logic [CNT_W-1:0]      first_mis_idx,
  output logic                  busy
);

  // Same layout as cone_res_t, sized by this instance's parameters.
  typedef struct packed {
    logic [OUT_W-1:0] val;
    logic [OUT_W-1:0] mis;
    logic [CNT_W-1:0] idx;
  } res_t;

  localparam int RES_W = $bits(res_t);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             first_vld_q, first_vld_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;

  logic [OUT_W-1:0] cone_val;
  res_t             res_in;
  res_t             res_out;
  logic             in_fire;
  logic             out_fire;

  // Element s is the input side of slice s; element STAGES is the output.
  logic [STAGES:0]  stg_valid;
  logic [STAGES:0]  stg_ready;
  logic [RES_W-1:0] stg_data [STAGES+1];

  // Cone evaluation sits ahead of slice 0, so the accept-to-output latency
  // is exactly the number of slices.
  for (genvar k = 0; k < OUT_W; k++) begin : g_cone
    assign cone_val[k] = xnor_reduce(MAX_IN_W'(in_vec),
                                     MAX_IN_W'(cfg_mask[k*IN_W +: IN_W]),
                                     cfg_inv[k]);
  end

  always_comb begin
    res_in     = '0;
    res_in.val = cone_val;
    res_in.mis = cone_val ^ in_exp;
    res_in.idx = idx_q;
  end

  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = res_in;
  assign in_ready          = stg_ready[0];
  assign stg_ready[STAGES] = out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    cone_pipe_slice #(
      .W (RES_W)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (stg_valid[s]),
      .in_ready  (stg_ready[s]),
      .in_data   (stg_data[s]),
      .out_valid (stg_valid[s+1]),
      .out_ready (stg_ready[s+1]),
      .out_data  (stg_data[s+1])
    );
  end

  assign res_out   = res_t'(stg_data[STAGES]);
  assign out_valid = stg_valid[STAGES];
  assign out_val   = res_out.val;
  assign out_mis   = res_out.mis;
  assign out_idx   = res_out.idx;
  assign busy      = |stg_valid[STAGES:1];

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    idx_d       = idx_q;
    mis_cnt_d   = mis_cnt_q;
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;

    if (in_fire) begin
      idx_d = idx_q + CNT_W'(1);
    end

    // clr takes priority: a mismatch leaving in the clr cycle is dropped.
    if (clr) begin
      mis_cnt_d   = '0;
      first_vld_d = 1'b0;
      first_idx_d = '0;
    end else if (out_fire && (|res_out.mis)) begin
      if (mis_cnt_q != '1) begin
        mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
      if (!first_vld_q) begin
        first_vld_d = 1'b1;
        first_idx_d = res_out.idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      mis_cnt_q   <= '0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else begin
      idx_q       <= idx_d;
      mis_cnt_q   <= mis_cnt_d;
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign mis_cnt       = mis_cnt_q;
  assign first_mis_vld = first_vld_q;
  assign first_mis_idx = first_idx_q;

endmodule

// File: tb/tb_cone_miter_pipe.sv
// tb/tb_cone_miter_pipe.sv - directed self-checking bench for cone_miter_pipe

module tb_cone_miter_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] cfg_mask;
  logic [3:0]  cfg_inv;
  logic        clr;
  logic        in_valid;
  logic [11:0] in_vec;
  logic [3:0]  in_exp;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_first_mis_vld, a_busy;
  logic [3:0]  a_out_val, a_out_mis;
  logic [15:0] a_out_idx, a_mis_cnt, a_first_mis_idx;

  logic        b_in_ready, b_out_valid, b_first_mis_vld, b_busy;
  logic [3:0]  b_out_val, b_out_mis;
  logic [3:0]  b_out_idx, b_mis_cnt, b_first_mis_idx;

  int n_run = 0;
  int n_fail = 0;

  logic [3:0]  got_val [$];
  logic [3:0]  got_mis [$];
  logic [15:0] got_idx [$];
  logic [3:0]  got_idx_b [$];
  int          acc_stall;
  logic        ir_stall;
  int          cyc_used;

  always #5 clk = ~clk;

  cone_miter_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_mask(cfg_mask), .cfg_inv(cfg_inv), .clr(clr),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_vec(in_vec), .in_exp(in_exp),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_val(a_out_val),
    .out_mis(a_out_mis), .out_idx(a_out_idx), .mis_cnt(a_mis_cnt),
    .first_mis_vld(a_first_mis_vld), .first_mis_idx(a_first_mis_idx), .busy(a_busy)
  );

  cone_miter_pipe #(.CNT_W(4)) u_dut_narrow (
    .clk(clk), .rst_n(rst_n), .cfg_mask(cfg_mask), .cfg_inv(cfg_inv), .clr(clr),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_vec(in_vec), .in_exp(in_exp),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_val(b_out_val),
    .out_mis(b_out_mis), .out_idx(b_out_idx), .mis_cnt(b_mis_cnt),
    .first_mis_vld(b_first_mis_vld), .first_mis_idx(b_first_mis_idx), .busy(b_busy)
  );

  // Stream configuration: ch0 parity of all bits, ch1 parity of low nibble,
  // ch2 empty mask inverted (constant 1), ch3 bit 11.
  function automatic logic [3:0] exp_of(input int j);
    logic [11:0] v;
    v = 12'(j);
    return {v[11], 1'b1, ^v[3:0], ^v};
  endfunction

  task automatic set_stream_cfg();
    cfg_mask = {12'h800, 12'h000, 12'h00F, 12'hFFF};
    cfg_inv  = 4'b0100;
  endtask

  task automatic clk_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    in_vec = '0; in_exp = '0;
    clk_step();
    clk_step();
    rst_n = 1'b1;
    clk_step();
  endtask

  // Pushes n vectors (in_vec = stream position), holding out_ready low for the
  // first 'stall' cycles, and collects every delivered result.
  task automatic run_stream(input int n, input int stall, input int bad_a,
                            input int bad_b, input bit all_bad);
    int sent = 0;
    int cyc = 0;
    bit bad;
    got_val.delete(); got_mis.delete(); got_idx.delete(); got_idx_b.delete();
    acc_stall = -1;
    ir_stall = 1'b1;
    while ((sent < n || got_val.size() < n) && cyc < 200) begin
      bad       = all_bad || (sent == bad_a) || (sent == bad_b);
      in_valid  = (sent < n);
      in_vec    = 12'(sent);
      in_exp    = exp_of(sent) ^ {3'b000, bad};
      out_ready = (cyc >= stall);
      clr       = 1'b0;
      if (cyc == stall) acc_stall = sent;
      #1;
      if (cyc == stall - 1) ir_stall = a_in_ready;
      if (in_valid && a_in_ready) sent++;
      if (a_out_valid && out_ready) begin
        got_val.push_back(a_out_val);
        got_mis.push_back(a_out_mis);
        got_idx.push_back(a_out_idx);
        got_idx_b.push_back(b_out_idx);
      end
      clk_step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc_used = cyc;
    n_run++;
    if (got_val.size() != n) begin
      n_fail++;
      $display("FAIL stream_delivered: got %0d results, want %0d", got_val.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    set_stream_cfg();
    n_run++;
    if ({a_in_ready, a_out_valid, a_busy, a_first_mis_vld} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 1000", {a_in_ready, a_out_valid, a_busy, a_first_mis_vld});
    end
    n_run++;
    if ({a_out_val, a_out_mis, a_out_idx, a_mis_cnt, a_first_mis_idx} !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h want 0", {a_out_val, a_out_mis, a_out_idx, a_mis_cnt, a_first_mis_idx});
    end
    run_stream(1, 0, 0, -1, 1'b0);
    in_valid = 1'b1; in_vec = 12'd5; in_exp = exp_of(5); out_ready = 1'b0;
    clk_step();
    in_vec = 12'd6; in_exp = exp_of(6);
    clk_step();
    in_valid = 1'b0;
    #1;
    n_run++;
    if ({a_busy, a_out_valid, a_in_ready, a_mis_cnt} !== {3'b110, 16'd1}) begin
      n_fail++;
      $display("FAIL reset_prestate: got %h want %h", {a_busy, a_out_valid, a_in_ready, a_mis_cnt}, {3'b110, 16'd1});
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({a_out_valid, a_in_ready, a_busy, a_first_mis_vld, a_mis_cnt} !== {4'b0100, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h want %h", {a_out_valid, a_in_ready, a_busy, a_first_mis_vld, a_mis_cnt}, {4'b0100, 16'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    clk_step();
  endtask

  task automatic test_single();
    do_reset();
    cfg_mask = 48'h000_000_000_003;
    cfg_inv  = 4'b0001;
    in_valid = 1'b1; in_vec = 12'h001; in_exp = 4'h0; out_ready = 1'b0;
    #1;
    n_run++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: got in_ready %b want 1", a_in_ready);
    end
    clk_step();
    in_valid = 1'b0;
    n_run++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat1: got out_valid %b want 0", a_out_valid);
    end
    clk_step();
    n_run++;
    if ({a_out_valid, a_out_val, a_out_mis, a_out_idx} !== {1'b1, 4'h0, 4'h0, 16'd0}) begin
      n_fail++;
      $display("FAIL single_lat2: got %h want %h", {a_out_valid, a_out_val, a_out_mis, a_out_idx}, {1'b1, 4'h0, 4'h0, 16'd0});
    end
    clk_step();
    n_run++;
    if ({a_out_valid, a_busy, a_out_val, a_out_idx} !== {2'b11, 4'h0, 16'd0}) begin
      n_fail++;
      $display("FAIL single_hold: got %h want %h", {a_out_valid, a_busy, a_out_val, a_out_idx}, {2'b11, 4'h0, 16'd0});
    end
    out_ready = 1'b1;
    clk_step();
    n_run++;
    if ({a_out_valid, a_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_drain: got %b want 00", {a_out_valid, a_busy});
    end
    cfg_inv = 4'b1001;
    in_valid = 1'b1; in_vec = 12'h003; in_exp = 4'h9;
    clk_step();
    in_valid = 1'b0;
    clk_step();
    n_run++;
    if ({a_out_valid, a_out_val, a_out_mis, a_out_idx} !== {1'b1, 4'h9, 4'h0, 16'd1}) begin
      n_fail++;
      $display("FAIL single_empty_mask: got %h want %h", {a_out_valid, a_out_val, a_out_mis, a_out_idx}, {1'b1, 4'h9, 4'h0, 16'd1});
    end
    clk_step();
    out_ready = 1'b0;
    n_run++;
    if (a_mis_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL single_miscnt: got %0d want 0", a_mis_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_stream_cfg();
    run_stream(6, 5, -1, -1, 1'b0);
    n_run++;
    if ({acc_stall, ir_stall} !== {32'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_fill: got accepted %0d in_ready %b want 2 0", acc_stall, ir_stall);
    end
    for (int i = 0; i < 6 && i < got_val.size(); i++) begin
      n_run++;
      if ({got_idx[i], got_val[i], got_mis[i]} !== {16'(i), exp_of(i), 4'h0}) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h want %h", i, {got_idx[i], got_val[i], got_mis[i]}, {16'(i), exp_of(i), 4'h0});
      end
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    set_stream_cfg();
    run_stream(10, 0, 3, 7, 1'b0);
    n_run++;
    if ({a_mis_cnt, a_first_mis_vld, a_first_mis_idx} !== {16'd2, 1'b1, 16'd3}) begin
      n_fail++;
      $display("FAIL mis_counters: got %h want %h", {a_mis_cnt, a_first_mis_vld, a_first_mis_idx}, {16'd2, 1'b1, 16'd3});
    end
    n_run++;
    if (got_val.size() == 10 && {got_mis[3], got_mis[7], got_mis[4]} !== 12'h110) begin
      n_fail++;
      $display("FAIL mis_flags: got %h want 110", {got_mis[3], got_mis[7], got_mis[4]});
    end
    n_run++;
    if (cyc_used !== 12) begin
      n_fail++;
      $display("FAIL back_to_back_cycles: got %0d want 12", cyc_used);
    end
  endtask

  task automatic test_clr();
    do_reset();
    set_stream_cfg();
    run_stream(1, 0, 0, -1, 1'b0);
    in_valid = 1'b1; in_vec = 12'd1; in_exp = exp_of(1) ^ 4'b0001; out_ready = 1'b0;
    clk_step();
    in_vec = 12'd2; in_exp = exp_of(2);
    clk_step();
    in_valid = 1'b0;
    clr = 1'b1; out_ready = 1'b1;
    #1;
    n_run++;
    if ({a_out_valid, a_out_mis, a_out_idx, a_mis_cnt} !== {1'b1, 4'h1, 16'd1, 16'd1}) begin
      n_fail++;
      $display("FAIL clr_pre: got %h want %h", {a_out_valid, a_out_mis, a_out_idx, a_mis_cnt}, {1'b1, 4'h1, 16'd1, 16'd1});
    end
    clk_step();
    clr = 1'b0;
    n_run++;
    if ({a_mis_cnt, a_first_mis_vld, a_first_mis_idx} !== {16'd0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL clr_wins: got %h want 0", {a_mis_cnt, a_first_mis_vld, a_first_mis_idx});
    end
    clk_step();
    run_stream(1, 0, 0, -1, 1'b0);
    n_run++;
    if ({a_mis_cnt, a_first_mis_vld, a_first_mis_idx} !== {16'd1, 1'b1, 16'd3}) begin
      n_fail++;
      $display("FAIL clr_relatch: got %h want %h", {a_mis_cnt, a_first_mis_vld, a_first_mis_idx}, {16'd1, 1'b1, 16'd3});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_stream_cfg();
    run_stream(20, 0, -1, -1, 1'b1);
    n_run++;
    if ({b_mis_cnt, b_first_mis_vld, b_first_mis_idx, b_busy} !== {4'd15, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_narrow: got %h want %h", {b_mis_cnt, b_first_mis_vld, b_first_mis_idx, b_busy}, {4'd15, 1'b1, 4'd0, 1'b0});
    end
    n_run++;
    if (a_mis_cnt !== 16'd20) begin
      n_fail++;
      $display("FAIL sat_wide_count: got %0d want 20", a_mis_cnt);
    end
    n_run++;
    if (got_val.size() == 20 && {got_idx_b[15], got_idx_b[16], got_idx[19]} !== {4'd15, 4'd0, 16'd19}) begin
      n_fail++;
      $display("FAIL sat_idx_wrap: got %h want %h", {got_idx_b[15], got_idx_b[16], got_idx[19]}, {4'd15, 4'd0, 16'd19});
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_vec = '0; in_exp = '0; cfg_mask = '0; cfg_inv = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_mismatch();
    test_clr();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
